// File: rtl/spi_port.sv
// spi_port: Z80 I/O front-end for the SD-card SPI shifter.
//
// Decodes a chip-select control port and an SPI data port on the low address
// byte. Holds the card chip-select register. Starts one shifter transfer per
// data-port access and returns the shifter's previous byte on data-port reads.
//
// Ports
//   clock, reset       system clock, asynchronous active-low reset
//   ne, pe             shifter negative / positive phase clock-enables
//   iorq, rd, wr, m1   Z80 bus strobes (all active-low)
//   a, di              Z80 low address byte and write data
//   do_o, oe           read data to the CPU; oe high while a data-port read decodes
//   wait_n             Z80 WAIT (active-low), low while an access is stalled
//   cs                 SD card chip select (active-low)
//   spi_io, spi_d      shifter start strobe and byte to load
//   spi_q              shifter byte (result of the previous transfer)
//   state_o            debug view of the FSM: 0 IDLE, 1 STALL, 2 ACCESS
//   busy_o             debug view of the busy counter
//
// Bus handshake: the CPU holds iorq/rd/wr for the whole access. A data-port
// access is accepted on a pe tick when the shifter is free. While it is not
// free the access parks in STALL with wait_n low. Acceptance raises spi_io
// exactly once. spi_io stays high until the bus cycle ends, so every access
// produces its own rising edge.
module spi_port #(
    parameter logic [7:0]  CTRL_PORT  = 8'hE7,
    parameter logic [7:0]  DATA_PORT  = 8'hEB,
    parameter int unsigned BUSY_TICKS = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ne,
    input  logic       pe,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic       m1,
    input  logic [7:0] a,
    input  logic [7:0] di,
    output logic [7:0] do_o,
    output logic       oe,
    output logic       wait_n,
    output logic       cs,
    output logic       spi_io,
    output logic [7:0] spi_d,
    input  logic [7:0] spi_q,
    output logic [1:0] state_o,
    output logic [4:0] busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STALL  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t     state_q;
    logic       spi_io_q;
    logic [7:0] spi_d_q;
    logic [4:0] busy_q;
    logic       cs_q;

    logic       acc;
    logic       data_hit;
    logic       ctrl_hit;
    logic       data_rd;
    logic       start;
    logic [7:0] load_byte;

    // Interrupt acknowledge (m1 low) also drives iorq low and must not decode.
    always_comb begin
        acc       = !iorq && m1 && (!rd || !wr);
        data_hit  = acc && (a == DATA_PORT);
        ctrl_hit  = acc && (a == CTRL_PORT);
        data_rd   = data_hit && !rd;
        load_byte = !wr ? di : 8'hFF;
        // A transfer starts on the pe tick where a data access is pending in
        // IDLE or STALL and the shifter has drained.
        start     = pe && data_hit && (busy_q == 5'd0) &&
                    ((state_q == S_IDLE) || (state_q == S_STALL));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            spi_io_q <= 1'b0;
            spi_d_q  <= 8'hFF;
            busy_q   <= 5'd0;
            cs_q     <= 1'b1;
        end else begin
            // Chip select is independent of the transfer machinery.
            if (pe && ctrl_hit && !wr) begin
                cs_q <= di[0];
            end

            // Load wins over a coincident ne decrement.
            if (start) begin
                busy_q <= 5'(BUSY_TICKS);
            end else if (ne && (busy_q != 5'd0)) begin
                busy_q <= busy_q - 5'd1;
            end

            if (pe) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            spi_d_q  <= load_byte;
                            spi_io_q <= 1'b1;
                            state_q  <= S_ACCESS;
                        end else if (data_hit) begin
                            state_q  <= S_STALL;
                        end
                    end
                    S_STALL: begin
                        if (!acc) begin
                            // Bus cycle ended without WAIT holding it: drop it.
                            state_q  <= S_IDLE;
                        end else if (start) begin
                            spi_d_q  <= load_byte;
                            spi_io_q <= 1'b1;
                            state_q  <= S_ACCESS;
                        end
                    end
                    S_ACCESS: begin
                        if (!acc) begin
                            spi_io_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                    default: begin
                        spi_io_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign do_o    = data_rd ? spi_q : 8'h00;
    assign oe      = data_rd;
    assign wait_n  = (state_q != S_STALL);
    assign cs      = cs_q;
    assign spi_io  = spi_io_q;
    assign spi_d   = spi_d_q;
    assign state_o = state_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_spi_port.sv
// Testbench for spi_port: randomized Z80 bus cycles against a reference model.
module tb_spi_port;

    localparam logic [7:0] CTRL = 8'hE7;
    localparam logic [7:0] DATA = 8'hEB;

    logic       clock = 1'b0;
    logic       reset;
    logic       ne, pe, iorq, rd, wr, m1;
    logic [7:0] a, di, spi_q;
    logic [7:0] do_o, spi_d;
    logic       oe, wait_n, cs, spi_io;
    logic [1:0] state_o;
    logic [4:0] busy_o;

    spi_port dut (
        .clock(clock), .reset(reset), .ne(ne), .pe(pe),
        .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .a(a), .di(di),
        .do_o(do_o), .oe(oe), .wait_n(wait_n), .cs(cs),
        .spi_io(spi_io), .spi_d(spi_d), .spi_q(spi_q),
        .state_o(state_o), .busy_o(busy_o)
    );

    // ---------------- clock / reset / clock-enables ----------------
    always #5 clock = ~clock;

    initial begin
        int ph;
        ph = 0;
        pe = 1'b0;
        ne = 1'b0;
        forever begin
            @(negedge clock);
            ph = (ph + 1) % 4;
            pe = (ph == 0);
            ne = (ph == 2);
        end
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passed = 0;
    // [9:8] stall expectation (0 none, 1 stalled, 2 either), [7:0] spi_d byte
    logic [9:0] exp_q[$];
    logic [7:0] exp_rd_q[$];
    int ne_total = 0;
    int last_strobe_ne = -1000;
    bit wait_seen = 1'b0;
    bit cs_m = 1'b1;

    task automatic chk(input string nm, input bit ok, input int got, input int want);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, want, want);
    endtask

    // ---------------- monitor ----------------
    bit prev_io = 1'b0;
    bit prev_oe = 1'b0;

    always @(posedge clock) begin
        bit ne_s;
        bit oe_m;
        logic [9:0] e;
        int gap;
        ne_s = ne;
        #1;
        if (!reset) begin
            prev_io = 1'b0;
            prev_oe = 1'b0;
            wait_seen = 1'b0;
            last_strobe_ne = -1000;
        end else begin
            if (ne_s) ne_total++;
            if (!wait_n) wait_seen = 1'b1;
            if (spi_io && !prev_io) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1'b0, int'(spi_d), 0);
                end else begin
                    e = exp_q.pop_front();
                    gap = ne_total - last_strobe_ne;
                    chk("strobe_data", spi_d == e[7:0], int'(spi_d), int'(e[7:0]));
                    chk("wait_released", wait_n == 1'b1, int'(wait_n), 1);
                    if (e[9:8] == 2'd1) begin
                        chk("stall_gap", gap == 18, gap, 18);
                        chk("stall_wait_seen", wait_seen, int'(wait_seen), 1);
                    end else if (e[9:8] == 2'd0) begin
                        chk("idle_gap", gap >= 18, gap, 18);
                        chk("idle_no_wait", !wait_seen, int'(wait_seen), 0);
                    end
                end
                last_strobe_ne = ne_total;
                wait_seen = 1'b0;
            end
            oe_m = !iorq && m1 && !rd && (a == DATA);
            if (oe_m || oe) chk("oe_decode", oe == oe_m, int'(oe), int'(oe_m));
            if (oe && !prev_oe) begin
                if (exp_rd_q.size() == 0) chk("unexpected_read", 1'b0, int'(do_o), 0);
                else begin
                    e[7:0] = exp_rd_q.pop_front();
                    chk("read_data", do_o == e[7:0], int'(do_o), int'(e[7:0]));
                end
            end
            prev_io = spi_io;
            prev_oe = oe;
        end
    end

    // ---------------- driver ----------------
    // Reference model: a transfer keeps the shifter busy for 18 ne ticks after
    // its strobe; a data access arriving earlier must wait for the 18th tick.
    function automatic logic [1:0] stall_kind();
        int since;
        since = ne_total - last_strobe_ne;
        if (since <= 16) return 2'd1;
        if (since >= 18) return 2'd0;
        return 2'd2;
    endfunction

    // For reads, data is the byte the shifter presents on spi_q.
    task automatic bus(input logic [7:0] addr, input logic [7:0] data,
                       input bit is_wr, input bit is_m1);
        int n;
        @(negedge clock);
        if (is_m1 && addr == DATA) begin
            exp_q.push_back({stall_kind(), is_wr ? data : 8'hFF});
            if (!is_wr) exp_rd_q.push_back(data);
        end
        if (is_m1 && addr == CTRL && is_wr) cs_m = data[0];
        if (!is_wr) spi_q = data;
        else di = data;
        a = addr;
        m1 = is_m1;
        iorq = 1'b0;
        if (is_wr) wr = 1'b0;
        else rd = 1'b0;
        repeat (8) @(negedge clock);
        n = 0;
        while (!wait_n && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("wait_bound", n < 400, n, 400);
        repeat (2) @(negedge clock);
        iorq = 1'b1;
        rd = 1'b1;
        wr = 1'b1;
        m1 = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int op;
        logic [7:0] r;
        reset = 1'b0;
        iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1;
        a = 8'h00; di = 8'h00; spi_q = 8'h00;
        #12;
        chk("rst_cs", cs == 1'b1, int'(cs), 1);
        chk("rst_wait_n", wait_n == 1'b1, int'(wait_n), 1);
        chk("rst_spi_io", spi_io == 1'b0, int'(spi_io), 0);
        chk("rst_spi_d", spi_d == 8'hFF, int'(spi_d), 255);
        chk("rst_oe", oe == 1'b0, int'(oe), 0);
        chk("rst_state", state_o == 2'd0, int'(state_o), 0);
        @(negedge clock);
        reset = 1'b1;
        idle(20);

        // chip select writes
        bus(CTRL, 8'h00, 1'b1, 1'b1);
        chk("cs_low", cs == cs_m, int'(cs), int'(cs_m));
        idle(4);
        bus(CTRL, 8'h01, 1'b1, 1'b1);
        chk("cs_high", cs == cs_m, int'(cs), int'(cs_m));
        idle(4);

        // single write, then busy drains
        bus(DATA, 8'h5A, 1'b1, 1'b1);
        idle(100);
        chk("busy_drained", busy_o == 5'd0, int'(busy_o), 0);

        // single read
        bus(DATA, 8'h3C, 1'b0, 1'b1);
        idle(100);

        // back-to-back writes: second one stalls
        bus(DATA, 8'h11, 1'b1, 1'b1);
        idle(4);
        bus(DATA, 8'h22, 1'b1, 1'b1);
        chk("wait_after_b2b", wait_n == 1'b1, int'(wait_n), 1);
        idle(4);

        // interrupt acknowledge with the data port address
        bus(DATA, 8'h99, 1'b0, 1'b0);
        idle(4);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    bus(CTRL, 8'($urandom_range(0, 1)), 1'b1, 1'b1);
                    chk("cs_rand", cs == cs_m, int'(cs), int'(cs_m));
                end
                1, 2: bus(DATA, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
                3: bus(DATA, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
                4: begin
                    r = 8'($urandom_range(0, 255));
                    while (r == CTRL || r == DATA) r = 8'($urandom_range(0, 255));
                    bus(r, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
                    chk("cs_other_port", cs == cs_m, int'(cs), int'(cs_m));
                end
                default: bus(DATA, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            endcase
            idle($urandom_range(4, 90));
        end

        // reset asserted while an access is stalled
        idle(100);
        bus(DATA, 8'h77, 1'b1, 1'b1);
        idle(4);
        @(negedge clock);
        a = DATA; di = 8'h88; m1 = 1'b1; iorq = 1'b0; wr = 1'b0;
        n = 0;
        while (wait_n && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("stall_entered", !wait_n, int'(wait_n), 0);
        #1 reset = 1'b0;
        #1;
        chk("rst_stall_wait_n", wait_n == 1'b1, int'(wait_n), 1);
        chk("rst_stall_state", state_o == 2'd0, int'(state_o), 0);
        chk("rst_stall_spi_io", spi_io == 1'b0, int'(spi_io), 0);
        chk("rst_stall_spi_d", spi_d == 8'hFF, int'(spi_d), 255);
        chk("rst_stall_busy", busy_o == 5'd0, int'(busy_o), 0);
        chk("rst_stall_cs", cs == 1'b1, int'(cs), 1);
        iorq = 1'b1; wr = 1'b1;
        cs_m = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(10);

        // first access after reset is accepted at once
        bus(DATA, 8'hA5, 1'b1, 1'b1);
        idle(100);

        chk("exp_q_drained", exp_q.size() == 0, exp_q.size(), 0);
        chk("exp_rd_q_drained", exp_rd_q.size() == 0, exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
